// File: rtl/dmux4x32_pkg.sv
// Shared definitions for the registered 1-to-4 word demultiplexer.
// Optional per-channel delivery counters are enabled with DMUX_COUNT_EN.
package dmux4x32_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam logic [31:0] DATA_RST = '0;

endpackage

// File: rtl/dmux4x32_reg_slot.sv
// One-entry output holding register with optional delivery counter.
// The counter is built only when DMUX_COUNT_EN is defined.
module dmux_slot
    import dmux4x32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] cnt
);

    // Fill wins over drain so a simultaneous drain+fill keeps the slot full with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= WIDTH'(DATA_RST);
        end else if (fill) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/dmux4x32_reg.sv
// Registered 1-to-4 demultiplexer: routes each accepted word to the slot chosen by in_sel.
// Define DMUX_COUNT_EN to enable the per-channel delivered-word counters on out_cnt.
module dmux4x32_reg
    import dmux4x32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  sel_t                    in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0] out_cnt
);

    logic              accept;
    logic [NUM_CH-1:0] fill;
    logic [NUM_CH-1:0] drain;

    // Only the addressed channel can stall the producer.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign fill[i] = accept & (in_sel == sel_t'(i));

        dmux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .fill  (fill[i]),
            .drain (drain[i]),
            .d     (in_data),
            .valid (out_valid[i]),
            .q     (out_data[i*WIDTH +: WIDTH]),
            .cnt   (out_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_dmux4x32_reg.sv
// Scoreboard bench for dmux4x32_reg; counter expectations follow DMUX_COUNT_EN.
module tb_dmux4x32_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [4*CNT_W-1:0] out_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q [4][$];

    dmux4x32_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; exp_rdy is the hand-derived in_ready for this cycle.
    task automatic send(input logic [31:0] data, input logic [1:0] sel, input logic exp_rdy);
        in_valid = 1'b1;
        in_data  = data;
        in_sel   = sel;
        @(negedge clk);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (exp_rdy) exp_q[sel].push_back(data);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flush();
        for (int c = 0; c < 4; c++) exp_q[c].delete();
    endtask

    // Monitor: every held word must match the oldest expected word for its channel.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("unexpected_word_ch%0d", c), 128'(out_data[c*WIDTH +: WIDTH]), 128'(0));
                        n_cmp++;
                        n_err++;
                        $display("FAIL scoreboard_empty_ch%0d: got valid word, required none", c);
                    end else begin
                        chk($sformatf("sb_data_ch%0d", c), 128'(out_data[c*WIDTH +: WIDTH]), 128'(exp_q[c][0]));
                        if (out_ready[c]) void'(exp_q[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt_pre, cnt_wrap;
        `ifdef DMUX_COUNT_EN
        cnt_pre  = 16'h0100;
        cnt_wrap = 16'hF000;
        `else
        cnt_pre  = 16'h0000;
        cnt_wrap = 16'h0000;
        `endif

        // 1. reset with a word on offer
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        tick();
        chk("rst_valid", 128'(out_valid), 128'(4'b0000));
        chk("rst_data", out_data, 128'(0));
        chk("rst_cnt", 128'(out_cnt), 128'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_rst_valid", 128'(out_valid), 128'(4'b0000));

        // 2. route to channel 2
        send(32'hF00000BA, 2'd2, 1'b1);
        chk("route_valid", 128'(out_valid), 128'(4'b0100));
        chk("route_data", out_data, {32'h0, 32'hF00000BA, 64'h0});

        // 3. backpressure on channel 2, channel 1 still flows
        send(32'h0000C000, 2'd2, 1'b0);
        chk("bp_valid", 128'(out_valid), 128'(4'b0100));
        chk("bp_hold", 128'(out_data[95:64]), 128'(32'hF00000BA));
        send(32'h0000C000, 2'd1, 1'b1);
        chk("bp_other_valid", 128'(out_valid), 128'(4'b0110));
        chk("bp_other_data", out_data, {32'h0, 32'hF00000BA, 32'h0000C000, 32'h0});

        // 4. drain and fill channel 2 in the same cycle
        out_ready = 4'b0100;
        send(32'h0000D000, 2'd2, 1'b1);
        out_ready = 4'b0000;
        chk("df_valid", 128'(out_valid), 128'(4'b0110));
        chk("df_data", 128'(out_data[95:64]), 128'(32'h0000D000));

        // 5. fill all four, then reset with every handshake active
        send(32'h00000011, 2'd0, 1'b1);
        send(32'h00000033, 2'd3, 1'b1);
        chk("full_valid", 128'(out_valid), 128'(4'b1111));
        chk("full_cnt", 128'(out_cnt), 128'(cnt_pre));
        rst       = 1'b1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 32'h55555555;
        in_sel    = 2'd0;
        flush();
        tick();
        chk("midrst_valid", 128'(out_valid), 128'(4'b0000));
        chk("midrst_data", out_data, 128'(0));
        chk("midrst_cnt", 128'(out_cnt), 128'(0));
        rst      = 1'b0;
        in_valid = 1'b0;

        // 6. sixteen deliveries on channel 3 wrap its 4-bit counter
        out_ready = 4'b1000;
        for (int k = 0; k < 16; k++) send(32'h30000000 + 32'(k), 2'd3, 1'b1);
        chk("cnt_15", 128'(out_cnt), 128'(cnt_wrap));
        tick();
        chk("cnt_wrap", 128'(out_cnt), 128'(0));
        chk("drain_valid", 128'(out_valid), 128'(4'b0000));
        chk("drain_holds_data", 128'(out_data[127:96]), 128'(32'h3000000F));
        chk("sb_empty_ch3", 128'(exp_q[3].size()), 128'(0));
        out_ready = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
